// File: rtl/regfile_pkg.sv
// Shared constants and types for the 8x8-bit register file and its read-side users.
package regfile_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        PRESENT,
        DONE
    } dump_state_t;

endpackage

// File: rtl/regfile_dumper.sv
// Walks a (possibly wrapping) register address range through one read port and
// streams each captured value with its address over a valid/ready interface.
module regfile_dumper
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] ra,
    input  logic [DATA_W-1:0] rd,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    dump_state_t       state_reg, state_next;
    logic [ADDR_W-1:0] cur_reg, cur_next;
    logic [ADDR_W-1:0] end_reg, end_next;
    logic [DATA_W-1:0] data_reg, data_next;
    logic [ADDR_W-1:0] addr_reg, addr_next;
    logic              valid_reg, valid_next;
    logic              last_reg, last_next;
    logic              done_reg, done_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cur_reg   <= '0;
            end_reg   <= '0;
            data_reg  <= '0;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
            last_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cur_reg   <= cur_next;
            end_reg   <= end_next;
            data_reg  <= data_next;
            addr_reg  <= addr_next;
            valid_reg <= valid_next;
            last_reg  <= last_next;
            done_reg  <= done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cur_next   = cur_reg;
        end_next   = end_reg;
        data_next  = data_reg;
        addr_next  = addr_reg;
        valid_next = valid_reg;
        last_next  = last_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    cur_next   = first_addr;
                    end_next   = last_addr;
                    state_next = READ;
                end
            end
            READ: begin
                // rd is combinational on ra, so the value is captured in this cycle
                data_next  = rd;
                addr_next  = cur_reg;
                last_next  = (cur_reg == end_reg);
                valid_next = 1'b1;
                state_next = PRESENT;
            end
            PRESENT: begin
                if (out_ready) begin
                    valid_next = 1'b0;
                    if (cur_reg == end_reg) begin
                        done_next  = 1'b1;
                        state_next = DONE;
                    end else begin
                        cur_next   = cur_reg + ADDR_W'(1);
                        state_next = READ;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign ra        = (state_reg == IDLE) ? '0 : cur_reg;
    assign busy      = (state_reg != IDLE);
    assign out_data  = data_reg;
    assign out_addr  = addr_reg;
    assign out_valid = valid_reg;
    assign out_last  = last_reg;
    assign done      = done_reg;

endmodule

// File: tb/tb_regfile_dumper.sv
// Randomized and directed scoreboard bench for regfile_dumper with a behavioural register file.
module tb_regfile_dumper;
    import regfile_pkg::*;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] last_addr;
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              done;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        bit                last;
    } beat_t;

    beat_t             sb[$];
    logic [DATA_W-1:0] rf_mem [NREGS];
    logic [DATA_W-1:0] model_regs [NREGS];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;
    int                mode = 0;

    regfile_dumper dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .ra         (ra),
        .rd         (rd),
        .out_data   (out_data),
        .out_addr   (out_addr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // Register file read port: register 0 is hardwired to zero.
    assign rd = (ra == '0) ? '0 : rf_mem[ra];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] model_read(input int a);
        return (a == 0) ? '0 : model_regs[a];
    endfunction

    task automatic write_reg(input int a, input logic [DATA_W-1:0] v);
        rf_mem[a]     = v;
        model_regs[a] = v;
    endtask

    // Monitor: scoreboard pops on accept, hold-stability and done-pulse checks.
    bit                pending_done = 0;
    bit                prev_stall = 0;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_last;

    always @(negedge clk) begin
        if (!rst) begin
            pending_done = 0;
            prev_stall   = 0;
        end else begin
            beat_t b;
            bit    acc_last;
            acc_last = 0;
            if (pending_done || done)
                chk("done_pulse", {31'd0, done}, {31'd0, pending_done});
            if (prev_stall) begin
                chk("hold_stable", {20'd0, out_valid, out_last, out_addr, out_data},
                    {20'd0, 1'b1, prev_last, prev_addr, prev_data});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got addr %0d data %0h expected none",
                             out_addr, out_data);
                end else begin
                    b = sb.pop_front();
                    $display("beat addr=%0d data=%02h last=%0b", out_addr, out_data, out_last);
                    chk("beat", {20'd0, out_last, out_addr, out_data},
                        {20'd0, b.last, b.addr, b.data});
                    acc_last = b.last;
                end
            end
            pending_done = acc_last;
            prev_stall   = out_valid && !out_ready;
            prev_data    = out_data;
            prev_addr    = out_addr;
            prev_last    = out_last;
        end
    end

    task automatic chk_reset_outputs(input string name);
        chk(name, {16'd0, ra, out_data, out_addr, out_valid, out_last, busy, done}, 32'd0);
    endtask

    task automatic do_dump(input logic [ADDR_W-1:0] f, input logic [ADDR_W-1:0] l,
                           input int rmode, input int stall, input bit wr_hook,
                           input bit glitch_busy, input bit glitch_done);
        int n, lat, busy_cycles, stalled, c0;
        bit seen;
        n = ((int'(l) - int'(f)) & (NREGS - 1)) + 1;
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.addr = ADDR_W'((int'(f) + i) % NREGS);
            b.data = model_read(int'(b.addr));
            b.last = (i == n - 1);
            sb.push_back(b);
        end
        mode = (stall > 0) ? 2 : rmode;
        @(posedge clk);
        #1;
        first_addr = f;
        last_addr  = l;
        start      = 1'b1;
        c0         = cyc;
        @(posedge clk);
        #1;
        start       = 1'b0;
        busy_cycles = 0;
        stalled     = 0;
        seen        = 0;
        lat         = 0;
        for (int k = 0; k < 400 && !seen; k++) begin
            @(negedge clk);
            if (busy) busy_cycles++;
            if (done) begin
                seen = 1;
                lat  = cyc - c0;
            end
            if (glitch_busy && k == 2) begin
                start      = 1'b1;
                first_addr = ~f;
                last_addr  = f;
            end
            if (glitch_busy && k == 3) start = 1'b0;
            if (stall > 0 && mode == 2 && out_valid) begin
                stalled++;
                if (stalled == stall) begin
                    chk("stalled_beat", {21'd0, out_valid, out_addr, out_data},
                        {21'd0, 1'b1, sb[0].addr, sb[0].data});
                    if (wr_hook) write_reg(int'(sb[0].addr), 8'hAA);
                    mode = rmode;
                end
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done after %0d beats", n);
        end
        $display("dump first=%0d last=%0d beats=%0d done_cycle=%0d busy_cycles=%0d",
                 f, l, n, lat, busy_cycles);
        if (seen && rmode == 0 && stall == 0 && !glitch_busy) begin
            chk("done_cycle", lat, 2 * n + 1);
            chk("busy_cycles", busy_cycles, 2 * n + 1);
        end
        if (glitch_done) begin
            start      = 1'b1;
            first_addr = '0;
            last_addr  = '1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            chk("start_in_done_busy", {31'd0, busy}, 32'd0);
            @(negedge clk);
            chk("start_in_done_idle", {30'd0, busy, out_valid}, 32'd0);
        end else begin
            @(negedge clk);
            chk("busy_after_done", {31'd0, busy}, 32'd0);
        end
        chk("sb_empty", sb.size(), 0);
    endtask

    initial begin
        bit got_valid;
        rst        = 1'b0;
        start      = 1'b0;
        first_addr = '0;
        last_addr  = '0;
        for (int i = 0; i < NREGS; i++) write_reg(i, DATA_W'(8'h11 * i));
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset_state");
        rst = 1'b1;

        // Full range, ready held high: done 17 cycles after start.
        do_dump(3'd0, 3'd7, 0, 0, 0, 0, 0);
        // Wrapping range.
        do_dump(3'd6, 3'd1, 0, 0, 0, 0, 0);
        // Single register with consumer stalled for 5 cycles.
        do_dump(3'd3, 3'd3, 0, 5, 0, 0, 0);
        // Start pulses while busy and in the DONE cycle are ignored.
        do_dump(3'd1, 3'd5, 0, 0, 0, 1, 1);
        // Write to the presented register does not alter the beat; next dump sees it.
        do_dump(3'd2, 3'd3, 0, 2, 1, 0, 0);
        do_dump(3'd2, 3'd2, 0, 0, 0, 0, 0);

        // Reset during PRESENT.
        sb.delete();
        mode = 2;
        @(posedge clk);
        #1;
        first_addr = 3'd0;
        last_addr  = 3'd7;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        got_valid = 0;
        for (int k = 0; k < 20 && !got_valid; k++) begin
            @(negedge clk);
            got_valid = out_valid;
        end
        chk("valid_before_reset", {31'd0, got_valid}, 32'd1);
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        sb.delete();
        @(negedge clk);
        chk_reset_outputs("reset_held");
        rst  = 1'b1;
        mode = 0;
        do_dump(3'd0, 3'd7, 0, 0, 0, 0, 0);

        // Randomized dumps with random contents and random consumer backpressure.
        for (int t = 0; t < 20; t++) begin
            for (int w = 0; w < 3; w++)
                write_reg($urandom_range(0, NREGS - 1), DATA_W'($urandom));
            do_dump(ADDR_W'($urandom), ADDR_W'($urandom), (t % 4 == 0) ? 0 : 1, 0, 0, 0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
